cntrl_decode_pipe: RTL and testbench
====================================

Name: cntrl_decode_pipe

Overview:
Parametrised successor to the combinational decode controller. It decodes the same LEGv8 subset and registers the ID/EX control bundle. It also owns the NZVC flag register with EX-to-ID flag forwarding, detects load-use hazards and inserts bubbles, and squashes the wrong-path instruction after a taken branch. It sits between the IF/ID instruction register and the EX stage. Optional full B.cond support, where the earlier decoder handled BLT only.

Parameters:
REG_ADDR_W, 5, register-index width for ex_rd and hazard compares
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3)
FULL_COND, 0, 0 = B.cond evaluates LT only (other conds not taken); 1 = EQ/NE/LT/GE/GT/LE
BR_FLUSH, 1, 1 = squash the instruction following a taken branch; 0 = no squash

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  async active-low reset
instr_valid  in  1  instr holds a real instruction
instr  in  32  IF/ID instruction
fast_zero  in  1  ID-stage zero test of Rt read data (CBZ)
ex_n, ex_z, ex_v, ex_c  in  1 each  flags produced by the instruction now in EX
reg2loc  out  1  comb, selects Rm (1) or Rt (0) for read port 2
br_tkn  out  1  comb, branch taken this cycle
unc_br  out  1  comb, unconditional branch
if_stall  out  1  comb, hold PC and IF/ID
illegal  out  1  comb, instr_valid with unrecognised opcode
ex_valid  out  1  reg, EX bundle is live
ex_reg_wr, ex_mem_wr, ex_mem_rd, ex_alu_src, ex_imm_add, ex_set_flg, ex_ldurb, ex_movz, ex_movk  out  1 each  reg, EX controls
ex_alu_op  out  3  reg
ex_transfer  out  4  reg, byte-lane mask (1000 = 64-bit, 0001 = byte)
ex_rd  out  REG_ADDR_W  reg, destination index
flags_q  out  4  reg, architectural {N,Z,V,C}

Behaviour:
- Reset (async, rst_n=0): all ex_* = 0, ex_valid = 0, flags_q = 0, FSM = RUN, stall counter = 0. Comb outputs follow from these values.
- Decode table (opcode field -> controls):
  - ADDI [31:22]=1001000100: alu_op 010, alu_src 1, reg_wr 1.
  - ADDS [31:21]=10101011000: alu_op 010, reg2loc 1, reg_wr 1, set_flg 1.
  - SUBS 11101011000: same as ADDS with alu_op 011.
  - LDUR 11111000010: mem_rd 1, reg_wr 1, imm_add 1, alu_src 1, transfer 1000.
  - STUR 11111000000: mem_wr 1, reg2loc 0, transfer 1000.
  - LDURB 00111000010 / STURB 00111000000: same as LDUR / STUR with transfer 0001; ldurb 1 on LDURB only.
  - MOVZ [31:23]=110100101 / MOVK 111100101: reg_wr 1, movz / movk.
  - B [31:26]=000101; B.cond [31:24]=01010100; CBZ [31:24]=10110100 (reg2loc 0).
  - All don't-cares are driven 0; no X on any output.
- ex_rd = instr[4:0]; forced to 31 for non-writing instructions.
- Bubble: ex_valid = 0 and all ex_* = 0. A bubble is loaded when instr_valid = 0, illegal = 1, FSM = STALL, or a squash is pending.
- Flag forwarding: eff_flags = {ex_n, ex_z, ex_v, ex_c} when ex_valid & ex_set_flg, else flags_q. flags_q <= {ex_n, ex_z, ex_v, ex_c} on the edge where ex_valid & ex_set_flg.
- br_tkn:
  - B: 1.
  - CBZ: fast_zero.
  - B.cond with FULL_COND = 0: cond 0xB (LT) -> N != V; any other cond -> 0.
  - B.cond with FULL_COND = 1, cond = instr[3:0]:
    - 0x0 EQ: Z; 0x1 NE: !Z.
    - 0xB LT: N != V; 0xA GE: N == V.
    - 0xC GT: !Z & N == V; 0xD LE: Z | N != V.
    - any other cond -> 0.
  - br_tkn and unc_br are gated by instr_valid and by FSM = RUN.
- Load-use hazard, checked only in RUN:
  - Condition: ex_valid & ex_mem_rd & ex_rd != 31, and ex_rd equals instr[9:5] or the port-2 register (instr[20:16] if reg2loc else instr[4:0]).
  - Response: if_stall = 1, load a bubble, go to STALL with counter = LOAD_STALL_CYCLES - 1.
- STALL: if_stall = 1 and bubbles are loaded while counter != 0; counter decrements each cycle. At counter = 0, if_stall = 0 and the held instruction is decoded normally; FSM returns to RUN.
- Squash (BR_FLUSH = 1): a taken branch in RUN sets squash_q. On the next edge the instruction then in IF/ID loads as a bubble and squash_q clears. A hazard check against a squashed instruction is suppressed.
- Simultaneous events: a hazard and a branch cannot coincide because the branch sources are not checked for load-use; reset overrides everything; rst_n asserted mid-STALL returns to RUN.

Test Plan:
- Reset -> flags_q = 0, ex_valid = 0. ADDI X1,X31,#5 (0x910017E1) -> next cycle ex_reg_wr = 1, ex_alu_src = 1, ex_alu_op = 010, ex_rd = 1.
- LDUR X2,[X1] (0xF8400022) then ADDS X3,X2,X2 (0xAB020043) -> 1 cycle of if_stall = 1 with a bubble. With LOAD_STALL_CYCLES = 3 -> 3 bubbles, then ADDS issues with ex_set_flg = 1.
- SUBS in EX with ex_n = 1, ex_v = 0, immediately followed by B.LT (0x5400004B) -> br_tkn = 1 using forwarded flags; flags_q = 1000 after the edge.
- FULL_COND = 1, flags_q Z = 1: B.EQ (0x54000040) -> br_tkn = 1; B.NE (0x54000041) -> 0; B.GT -> 0. With FULL_COND = 0, B.EQ -> br_tkn = 0.
- CBZ with fast_zero = 1 -> br_tkn = 1, unc_br = 0; next instruction is squashed (ex_valid = 0). Unknown opcode 0xFFFFFFFF -> illegal = 1, bubble.
- rst_n dropped during STALL -> outputs reset immediately, FSM = RUN after release.

Source files
------------

// File: rtl/cntrl_decode_pipe.sv
// Pipelined LEGv8 decode controller: decodes the IF/ID instruction, registers the ID/EX
// control bundle, owns the NZVC flags, inserts load-use bubbles and squashes wrong-path fetches.
module cntrl_decode_pipe #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,    // legal range 1..3
    parameter bit FULL_COND         = 1'b0,
    parameter bit BR_FLUSH          = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    input  logic [31:0]           instr,
    input  logic                  fast_zero,
    input  logic                  ex_n,
    input  logic                  ex_z,
    input  logic                  ex_v,
    input  logic                  ex_c,
    output logic                  reg2loc,
    output logic                  br_tkn,
    output logic                  unc_br,
    output logic                  if_stall,
    output logic                  illegal,
    output logic                  ex_valid,
    output logic                  ex_reg_wr,
    output logic                  ex_mem_wr,
    output logic                  ex_mem_rd,
    output logic                  ex_alu_src,
    output logic                  ex_imm_add,
    output logic                  ex_set_flg,
    output logic                  ex_ldurb,
    output logic                  ex_movz,
    output logic                  ex_movk,
    output logic [2:0]            ex_alu_op,
    output logic [3:0]            ex_transfer,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [3:0]            flags_q
);

    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_LDURB = 11'b00111000010;
    localparam logic [10:0] OP_STURB = 11'b00111000000;
    localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
    localparam logic [8:0]  OP_MOVK  = 9'b111100101;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;

    localparam logic [REG_ADDR_W-1:0] REG_ZR     = REG_ADDR_W'(31);
    localparam logic [1:0]            STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

    typedef enum logic {
        RUN,
        STALL
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic                  reg_wr;
        logic                  mem_wr;
        logic                  mem_rd;
        logic                  alu_src;
        logic                  imm_add;
        logic                  set_flg;
        logic                  ldurb;
        logic                  movz;
        logic                  movk;
        logic [2:0]            alu_op;
        logic [3:0]            transfer;
        logic [REG_ADDR_W-1:0] rd;
    } ex_bundle_t;

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       squash_q, squash_d;
    ex_bundle_t ex_q, ex_d;
    ex_bundle_t dec;

    logic       legal;
    logic       is_b, is_bcond, is_cbz;
    logic       dec_reg2loc;
    logic [3:0] eff_flags;
    logic       cond_ok;
    logic       lt;
    logic       run;
    logic [4:0] port2;
    logic       load_use;
    logic       hazard;
    logic       bubble;

    // Opcode fields consulted by no instruction in this subset, and the carry flag,
    // which no supported condition tests.
    logic unused_ok;
    assign unused_ok = ^{instr[15:10], eff_flags[0]};

    // NOTE: every variable written in an always_comb gets a default first, so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        dec         = '0;
        dec_reg2loc = 1'b0;
        legal       = 1'b0;
        is_b        = 1'b0;
        is_bcond    = 1'b0;
        is_cbz      = 1'b0;
        if (instr[31:22] == OP_ADDI) begin
            legal       = 1'b1;
            dec.alu_op  = 3'b010;
            dec.alu_src = 1'b1;
            dec.reg_wr  = 1'b1;
        end else if (instr[31:21] == OP_ADDS || instr[31:21] == OP_SUBS) begin
            legal       = 1'b1;
            dec.alu_op  = (instr[30]) ? 3'b011 : 3'b010;
            dec_reg2loc = 1'b1;
            dec.reg_wr  = 1'b1;
            dec.set_flg = 1'b1;
        end else if (instr[31:21] == OP_LDUR || instr[31:21] == OP_LDURB) begin
            legal        = 1'b1;
            dec.mem_rd   = 1'b1;
            dec.reg_wr   = 1'b1;
            dec.imm_add  = 1'b1;
            dec.alu_src  = 1'b1;
            dec.ldurb    = (instr[31:21] == OP_LDURB);
            dec.transfer = (instr[31:21] == OP_LDURB) ? 4'b0001 : 4'b1000;
        end else if (instr[31:21] == OP_STUR || instr[31:21] == OP_STURB) begin
            legal        = 1'b1;
            dec.mem_wr   = 1'b1;
            dec.transfer = (instr[31:21] == OP_STURB) ? 4'b0001 : 4'b1000;
        end else if (instr[31:23] == OP_MOVZ) begin
            legal      = 1'b1;
            dec.reg_wr = 1'b1;
            dec.movz   = 1'b1;
        end else if (instr[31:23] == OP_MOVK) begin
            legal      = 1'b1;
            dec.reg_wr = 1'b1;
            dec.movk   = 1'b1;
        end else if (instr[31:26] == OP_B) begin
            legal = 1'b1;
            is_b  = 1'b1;
        end else if (instr[31:24] == OP_BCOND) begin
            legal    = 1'b1;
            is_bcond = 1'b1;
        end else if (instr[31:24] == OP_CBZ) begin
            legal  = 1'b1;
            is_cbz = 1'b1;
        end
        dec.valid = legal;
        dec.rd    = dec.reg_wr ? REG_ADDR_W'(instr[4:0]) : REG_ZR;
    end

    // A flag-setting instruction in EX has not yet written flags_q; a B.cond right behind
    // it must see its result.
    assign eff_flags = (ex_q.valid && ex_q.set_flg) ? {ex_n, ex_z, ex_v, ex_c} : flags_q;
    assign lt        = eff_flags[3] ^ eff_flags[1];

    always_comb begin
        cond_ok = 1'b0;
        if (FULL_COND) begin
            case (instr[3:0])
                4'h0:    cond_ok = eff_flags[2];
                4'h1:    cond_ok = !eff_flags[2];
                4'hA:    cond_ok = !lt;
                4'hB:    cond_ok = lt;
                4'hC:    cond_ok = !eff_flags[2] && !lt;
                4'hD:    cond_ok = eff_flags[2] || lt;
                default: cond_ok = 1'b0;
            endcase
        end else begin
            cond_ok = (instr[3:0] == 4'hB) && lt;
        end
    end

    assign run     = (state_q == RUN);
    assign illegal = instr_valid && !legal;
    assign reg2loc = dec_reg2loc;
    // A fetch that is about to be squashed is wrong-path and must not redirect the PC.
    assign br_tkn  = instr_valid && run && !squash_q &&
                     (is_b || (is_cbz && fast_zero) || (is_bcond && cond_ok));
    assign unc_br  = instr_valid && run && !squash_q && is_b;

    // Branch operands are resolved in ID and never wait on a load, so branches are excluded.
    assign port2    = dec_reg2loc ? instr[20:16] : instr[4:0];
    assign load_use = ex_q.valid && ex_q.mem_rd && (ex_q.rd != REG_ZR) &&
                      ((ex_q.rd == REG_ADDR_W'(instr[9:5])) || (ex_q.rd == REG_ADDR_W'(port2)));
    assign hazard   = run && !squash_q && instr_valid && legal &&
                      !(is_b || is_bcond || is_cbz) && load_use;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        if_stall = 1'b0;
        case (state_q)
            RUN: begin
                if (hazard) begin
                    if_stall = 1'b1;
                    state_d  = STALL;
                    cnt_d    = STALL_INIT;
                end
            end
            STALL: begin
                if (cnt_q != 2'd0) begin
                    if_stall = 1'b1;
                    cnt_d    = cnt_q - 2'd1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        squash_d = BR_FLUSH && br_tkn;
        bubble   = !instr_valid || illegal || if_stall || squash_q;
        ex_d     = bubble ? '0 : dec;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            cnt_q    <= 2'd0;
            squash_q <= 1'b0;
            ex_q     <= '0;
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            squash_q <= squash_d;
            ex_q     <= ex_d;
            if (ex_q.valid && ex_q.set_flg) begin
                flags_q <= {ex_n, ex_z, ex_v, ex_c};
            end
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_reg_wr   = ex_q.reg_wr;
    assign ex_mem_wr   = ex_q.mem_wr;
    assign ex_mem_rd   = ex_q.mem_rd;
    assign ex_alu_src  = ex_q.alu_src;
    assign ex_imm_add  = ex_q.imm_add;
    assign ex_set_flg  = ex_q.set_flg;
    assign ex_ldurb    = ex_q.ldurb;
    assign ex_movz     = ex_q.movz;
    assign ex_movk     = ex_q.movk;
    assign ex_alu_op   = ex_q.alu_op;
    assign ex_transfer = ex_q.transfer;
    assign ex_rd       = ex_q.rd;

endmodule

// File: tb/tb_cntrl_decode_pipe.sv
// Directed bench for cntrl_decode_pipe: a default instance (scoreboarded EX bundle) and a
// 3-cycle-stall / full-condition / no-flush instance sharing the same stimulus.
module tb_cntrl_decode_pipe;

    typedef logic [21:0] ex_t;  // {valid,reg_wr,mem_wr,mem_rd,alu_src,imm_add,set_flg,ldurb,movz,movk, alu_op, transfer, rd}

    localparam logic [31:0] I_ADDI  = 32'h910017E1;
    localparam logic [31:0] I_LDUR  = 32'hF8400022;
    localparam logic [31:0] I_ADDS  = 32'hAB020043;
    localparam logic [31:0] I_SUBS  = 32'hEB020024;
    localparam logic [31:0] I_BLT   = 32'h5400004B;
    localparam logic [31:0] I_BEQ   = 32'h54000040;
    localparam logic [31:0] I_BNE   = 32'h54000041;
    localparam logic [31:0] I_BGT   = 32'h5400004C;
    localparam logic [31:0] I_BLE   = 32'h5400004D;
    localparam logic [31:0] I_CBZ   = 32'hB4000041;
    localparam logic [31:0] I_STUR  = 32'hF8000022;
    localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;
    localparam logic [31:0] I_B     = 32'h14000002;
    localparam logic [31:0] I_LDURB = 32'h38400022;
    localparam logic [31:0] I_MOVZ  = 32'hD2800025;
    localparam logic [31:0] I_MOVK  = 32'hF2800026;
    localparam logic [31:0] I_STURB = 32'h38000022;

    localparam ex_t E_BUB   = '0;
    localparam ex_t E_ADDI  = {10'b1100100000, 3'b010, 4'b0000, 5'd1};
    localparam ex_t E_LDUR  = {10'b1101110000, 3'b000, 4'b1000, 5'd2};
    localparam ex_t E_ADDS  = {10'b1100001000, 3'b010, 4'b0000, 5'd3};
    localparam ex_t E_SUBS  = {10'b1100001000, 3'b011, 4'b0000, 5'd4};
    localparam ex_t E_BR    = {10'b1000000000, 3'b000, 4'b0000, 5'd31};
    localparam ex_t E_STURB = {10'b1010000000, 3'b000, 4'b0001, 5'd31};
    localparam ex_t E_LDURB = {10'b1101110100, 3'b000, 4'b0001, 5'd2};
    localparam ex_t E_MOVZ  = {10'b1100000010, 3'b000, 4'b0000, 5'd5};
    localparam ex_t E_MOVK  = {10'b1100000001, 3'b000, 4'b0000, 5'd6};

    logic        clk, rst_n;
    logic        instr_valid, fast_zero, ex_n, ex_z, ex_v, ex_c;
    logic [31:0] instr;

    logic       a_reg2loc, a_br_tkn, a_unc_br, a_if_stall, a_illegal;
    logic       a_ex_valid, a_ex_reg_wr, a_ex_mem_wr, a_ex_mem_rd, a_ex_alu_src, a_ex_imm_add;
    logic       a_ex_set_flg, a_ex_ldurb, a_ex_movz, a_ex_movk;
    logic [2:0] a_ex_alu_op;
    logic [3:0] a_ex_transfer, a_flags_q;
    logic [4:0] a_ex_rd;

    logic       b_reg2loc, b_br_tkn, b_unc_br, b_if_stall, b_illegal;
    logic       b_ex_valid, b_ex_reg_wr, b_ex_mem_wr, b_ex_mem_rd, b_ex_alu_src, b_ex_imm_add;
    logic       b_ex_set_flg, b_ex_ldurb, b_ex_movz, b_ex_movk;
    logic [2:0] b_ex_alu_op;
    logic [3:0] b_ex_transfer, b_flags_q;
    logic [4:0] b_ex_rd;

    int    n_checks = 0;
    int    n_fail   = 0;
    ex_t   sb_q[$];
    string tag_q[$];

    cntrl_decode_pipe dut_a (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .fast_zero(fast_zero), .ex_n(ex_n), .ex_z(ex_z), .ex_v(ex_v), .ex_c(ex_c),
        .reg2loc(a_reg2loc), .br_tkn(a_br_tkn), .unc_br(a_unc_br), .if_stall(a_if_stall),
        .illegal(a_illegal), .ex_valid(a_ex_valid), .ex_reg_wr(a_ex_reg_wr),
        .ex_mem_wr(a_ex_mem_wr), .ex_mem_rd(a_ex_mem_rd), .ex_alu_src(a_ex_alu_src),
        .ex_imm_add(a_ex_imm_add), .ex_set_flg(a_ex_set_flg), .ex_ldurb(a_ex_ldurb),
        .ex_movz(a_ex_movz), .ex_movk(a_ex_movk), .ex_alu_op(a_ex_alu_op),
        .ex_transfer(a_ex_transfer), .ex_rd(a_ex_rd), .flags_q(a_flags_q)
    );

    cntrl_decode_pipe #(
        .LOAD_STALL_CYCLES(3), .FULL_COND(1'b1), .BR_FLUSH(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .fast_zero(fast_zero), .ex_n(ex_n), .ex_z(ex_z), .ex_v(ex_v), .ex_c(ex_c),
        .reg2loc(b_reg2loc), .br_tkn(b_br_tkn), .unc_br(b_unc_br), .if_stall(b_if_stall),
        .illegal(b_illegal), .ex_valid(b_ex_valid), .ex_reg_wr(b_ex_reg_wr),
        .ex_mem_wr(b_ex_mem_wr), .ex_mem_rd(b_ex_mem_rd), .ex_alu_src(b_ex_alu_src),
        .ex_imm_add(b_ex_imm_add), .ex_set_flg(b_ex_set_flg), .ex_ldurb(b_ex_ldurb),
        .ex_movz(b_ex_movz), .ex_movk(b_ex_movk), .ex_alu_op(b_ex_alu_op),
        .ex_transfer(b_ex_transfer), .ex_rd(b_ex_rd), .flags_q(b_flags_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic ex_t obs_a();
        return {a_ex_valid, a_ex_reg_wr, a_ex_mem_wr, a_ex_mem_rd, a_ex_alu_src, a_ex_imm_add,
                a_ex_set_flg, a_ex_ldurb, a_ex_movz, a_ex_movk, a_ex_alu_op, a_ex_transfer, a_ex_rd};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        check(tag, 32'(obs), 32'(exp));
    endtask

    // Drive one IF/ID slot and queue the EX bundle dut_a must hold after the next edge.
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic fz, input logic [3:0] f, input ex_t exp);
        instr_valid = v;
        instr       = ins;
        fast_zero   = fz;
        {ex_n, ex_z, ex_v, ex_c} = f;
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
    endtask

    task automatic tick();
        ex_t   exp;
        string tag;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL sb_empty: observed no queued entry expected one");
        end else begin
            exp = sb_q.pop_front();
            tag = tag_q.pop_front();
            check(tag, 32'(obs_a()), 32'(exp));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        fast_zero   = 1'b0;
        {ex_n, ex_z, ex_v, ex_c} = 4'b0000;
        @(posedge clk);
        #1;
        check("rst_bundle", 32'(obs_a()), 32'(E_BUB));
        check("rst_flags_a", 32'(a_flags_q), 32'h0);
        check("rst_flags_b", 32'(b_flags_q), 32'h0);
        chk1("rst_stall", a_if_stall, 1'b0);
        chk1("rst_br", a_br_tkn, 1'b0);
        rst_n = 1'b1;

        step("addi", 1, I_ADDI, 0, 4'b0000, E_ADDI);
        chk1("addi_illegal", a_illegal, 1'b0);
        tick();
        step("ldur", 1, I_LDUR, 0, 4'b0000, E_LDUR);
        tick();
        // Load-use: dut_a one bubble, dut_b three.
        step("hz_bubble", 1, I_ADDS, 0, 4'b0000, E_BUB);
        chk1("hz_stall_a", a_if_stall, 1'b1);
        chk1("hz_stall_b", b_if_stall, 1'b1);
        chk1("adds_reg2loc", a_reg2loc, 1'b1);
        tick();
        chk1("b_bubble1", b_ex_valid, 1'b0);
        step("adds_after_stall", 1, I_ADDS, 0, 4'b0000, E_ADDS);
        chk1("stall_rel_a", a_if_stall, 1'b0);
        chk1("stall2_b", b_if_stall, 1'b1);
        tick();
        chk1("b_bubble2", b_ex_valid, 1'b0);
        step("adds_rep1", 1, I_ADDS, 0, 4'b0000, E_ADDS);
        chk1("stall3_b", b_if_stall, 1'b1);
        tick();
        chk1("b_bubble3", b_ex_valid, 1'b0);
        step("adds_rep2", 1, I_ADDS, 0, 4'b0000, E_ADDS);
        chk1("stall_rel_b", b_if_stall, 1'b0);
        tick();
        chk1("b_adds_valid", b_ex_valid, 1'b1);
        chk1("b_adds_setflg", b_ex_set_flg, 1'b1);

        step("subs", 1, I_SUBS, 0, 4'b0000, E_SUBS);
        tick();
        // SUBS in EX reports N=1, V=0: B.LT must use the forwarded flags.
        step("blt", 1, I_BLT, 0, 4'b1000, E_BR);
        chk1("blt_fwd_a", a_br_tkn, 1'b1);
        chk1("blt_fwd_b", b_br_tkn, 1'b1);
        chk1("blt_unc", a_unc_br, 1'b0);
        check("flags_pre", 32'(a_flags_q), 32'h0);
        tick();
        step("squash_addi", 1, I_ADDI, 0, 4'b0000, E_BUB);
        check("flags_post_a", 32'(a_flags_q), 32'h8);
        check("flags_post_b", 32'(b_flags_q), 32'h8);
        tick();
        chk1("b_noflush", b_ex_valid, 1'b1);

        step("subs2", 1, I_SUBS, 0, 4'b0000, E_SUBS);
        tick();
        step("beq", 1, I_BEQ, 0, 4'b0100, E_BR);
        chk1("beq_lt_only_a", a_br_tkn, 1'b0);
        chk1("beq_full_b", b_br_tkn, 1'b1);
        tick();
        // EX holds a branch now, so the driven EX flags must be ignored.
        step("bne", 1, I_BNE, 0, 4'b1011, E_BR);
        check("flags_z_b", 32'(b_flags_q), 32'h4);
        chk1("bne_b", b_br_tkn, 1'b0);
        tick();
        step("bgt", 1, I_BGT, 0, 4'b0000, E_BR);
        chk1("bgt_b", b_br_tkn, 1'b0);
        tick();
        step("ble", 1, I_BLE, 0, 4'b0000, E_BR);
        chk1("ble_b", b_br_tkn, 1'b1);
        chk1("ble_a", a_br_tkn, 1'b0);
        tick();

        step("cbz", 1, I_CBZ, 1, 4'b0000, E_BR);
        chk1("cbz_br", a_br_tkn, 1'b1);
        chk1("cbz_unc", a_unc_br, 1'b0);
        chk1("cbz_reg2loc", a_reg2loc, 1'b0);
        tick();
        step("cbz_squash", 1, I_STUR, 0, 4'b0000, E_BUB);
        chk1("stur_reg2loc", a_reg2loc, 1'b0);
        tick();
        chk1("b_stur_memwr", b_ex_mem_wr, 1'b1);
        step("illegal_bubble", 1, I_BAD, 0, 4'b0000, E_BUB);
        chk1("illegal", a_illegal, 1'b1);
        tick();
        step("b_uncond", 1, I_B, 0, 4'b0000, E_BR);
        chk1("b_br", a_br_tkn, 1'b1);
        chk1("b_unc", a_unc_br, 1'b1);
        tick();
        step("b_squash", 1, I_LDURB, 0, 4'b0000, E_BUB);
        tick();
        step("ldurb", 1, I_LDURB, 0, 4'b0000, E_LDURB);
        tick();
        step("movz", 1, I_MOVZ, 0, 4'b0000, E_MOVZ);
        chk1("movz_nohz", a_if_stall, 1'b0);
        tick();
        step("movk", 1, I_MOVK, 0, 4'b0000, E_MOVK);
        tick();
        step("invalid", 0, I_B, 0, 4'b0000, E_BUB);
        chk1("invalid_br", a_br_tkn, 1'b0);
        chk1("invalid_illegal", a_illegal, 1'b0);
        tick();
        step("sturb", 1, I_STURB, 0, 4'b0000, E_STURB);
        tick();

        // Reset in the middle of dut_b's three-cycle stall.
        step("ldur2", 1, I_LDUR, 0, 4'b0000, E_LDUR);
        tick();
        step("hz2_bubble", 1, I_ADDS, 0, 4'b0000, E_BUB);
        chk1("hz2_stall_b", b_if_stall, 1'b1);
        tick();
        instr_valid = 1'b1;
        instr       = I_ADDS;
        #1;
        chk1("mid_stall_b", b_if_stall, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rst_mid_valid_b", b_ex_valid, 1'b0);
        chk1("rst_mid_stall_b", b_if_stall, 1'b0);
        check("rst_mid_flags_b", 32'(b_flags_q), 32'h0);
        check("rst_mid_bundle_a", 32'(obs_a()), 32'(E_BUB));
        rst_n = 1'b1;
        step("adds_after_rst", 1, I_ADDS, 0, 4'b0000, E_ADDS);
        tick();
        chk1("b_run_after_rst", b_ex_valid, 1'b1);
        chk1("b_setflg_after_rst", b_ex_set_flg, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
